regfile_wb_queue: RTL and testbench

Write-back queue on the write side of the integer register file. Accepts completed results (destination register + data) from the execute/memory stages over a valid/ready handshake, and buffers up to DEPTH of them in order. It drains one entry per cycle into the register file write port (`reg_write`, `write_addr`, `write_data`). It also forwards the youngest pending value for two read addresses, so decode never reads a stale register while a write is still queued.

---
 rtl/regfile_wb_queue_if.sv | 43 ++++
 rtl/regfile_wb_queue.sv | 95 +++++++++
 tb/tb_regfile_wb_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Handshake and port bundle for the register-file write-back queue.
// master: producer / register-file / decode side; slave: the queue.
interface regfile_wb_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  wb_stall;
   logic                  reg_write;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [ADDR_WIDTH-1:0] fwd_addr1;
   logic [ADDR_WIDTH-1:0] fwd_addr2;
   logic                  fwd_hit1;
   logic                  fwd_hit2;
   logic [DATA_WIDTH-1:0] fwd_data1;
   logic [DATA_WIDTH-1:0] fwd_data2;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  empty;

   modport master (
      output in_valid, in_rd, in_data, wb_stall,
      output fwd_addr1, fwd_addr2,
      input  in_ready, reg_write, write_addr, write_data,
      input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
      input  count, full, empty
   );

   modport slave (
      input  in_valid, in_rd, in_data, wb_stall,
      input  fwd_addr1, fwd_addr2,
      output in_ready, reg_write, write_addr, write_data,
      output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
      output count, full, empty
   );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue in front of the register file write port,
// with youngest-entry forwarding for two decode read indices.
module regfile_wb_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   regfile_wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] r_rd   [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_hit1;
   logic                  w_hit2;
   logic [DATA_WIDTH-1:0] w_dat1;
   logic [DATA_WIDTH-1:0] w_dat2;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   // x0 writes complete the handshake but are never stored
   assign w_push  = bus.in_valid && !w_full && (bus.in_rd != '0);
   assign w_pop   = !w_empty && !bus.wb_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_rd[r_tail]   <= bus.in_rd;
            r_data[r_tail] <= bus.in_data;
            r_tail         <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Walk oldest to youngest so the last match wins
   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      w_dat1 = '0;
      w_dat2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < r_count) begin
            if (bus.fwd_addr1 != '0 &&
                r_rd[r_head + PW'(i)] == bus.fwd_addr1) begin
               w_hit1 = 1'b1;
               w_dat1 = r_data[r_head + PW'(i)];
            end
            if (bus.fwd_addr2 != '0 &&
                r_rd[r_head + PW'(i)] == bus.fwd_addr2) begin
               w_hit2 = 1'b1;
               w_dat2 = r_data[r_head + PW'(i)];
            end
         end
      end
   end

   assign bus.in_ready   = !w_full;
   assign bus.reg_write  = w_pop;
   assign bus.write_addr = r_rd[r_head];
   assign bus.write_data = r_data[r_head];
   assign bus.fwd_hit1   = w_hit1;
   assign bus.fwd_hit2   = w_hit2;
   assign bus.fwd_data1  = w_dat1;
   assign bus.fwd_data2  = w_dat2;
   assign bus.count      = r_count;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomised scoreboard bench for regfile_wb_queue against a
// queue-based model of pending register writes.
module tb_regfile_wb_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   ent_t q[$];
   ent_t pend;
   bit   pend_v;

   regfile_wb_queue_if bus ();

   regfile_wb_queue dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act,
                               logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endfunction

   // Monitor: model holds exactly the entries stored in the DUT
   always @(negedge clk) begin
      logic        h1, h2, exp_rw;
      logic [31:0] d1, d2;
      ent_t        e;
      h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
      foreach (q[i]) begin
         if (bus.fwd_addr1 != 0 && q[i].rd == bus.fwd_addr1) begin
            h1 = 1'b1; d1 = q[i].d;
         end
         if (bus.fwd_addr2 != 0 && q[i].rd == bus.fwd_addr2) begin
            h2 = 1'b1; d2 = q[i].d;
         end
      end
      chk("count", 64'(bus.count), 64'(q.size()));
      chk("full", 64'(bus.full), 64'(q.size() == DEPTH));
      chk("empty", 64'(bus.empty), 64'(q.size() == 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
      chk("fwd_hit1", 64'(bus.fwd_hit1), 64'(h1));
      chk("fwd_data1", 64'(bus.fwd_data1), 64'(d1));
      chk("fwd_hit2", 64'(bus.fwd_hit2), 64'(h2));
      chk("fwd_data2", 64'(bus.fwd_data2), 64'(d2));
      exp_rw = (q.size() > 0) && !bus.wb_stall;
      chk("reg_write", 64'(bus.reg_write), 64'(exp_rw));
      if (exp_rw) begin
         e = q.pop_front();
         chk("write_addr", 64'(bus.write_addr), 64'(e.rd));
         chk("write_data", 64'(bus.write_data), 64'(e.d));
      end
   end

   task automatic cycle(input bit v, input logic [4:0] rd,
                        input logic [31:0] d, input bit st,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(posedge clk);
      if (pend_v) begin
         q.push_back(pend);
         pend_v = 1'b0;
      end
      #1;
      bus.in_valid  = v;
      bus.in_rd     = rd;
      bus.in_data   = d;
      bus.wb_stall  = st;
      bus.fwd_addr1 = a1;
      bus.fwd_addr2 = a2;
      if (v && q.size() < DEPTH && rd != 0) begin
         pend   = '{rd: rd, d: d};
         pend_v = 1'b1;
      end
   endtask

   task automatic idle(input int n, input bit st);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, st, 0, 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      pend_v   = 1'b0;
      rst_n    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_rd     = '0;
      bus.in_data   = '0;
      bus.wb_stall  = 1'b0;
      bus.fwd_addr1 = '0;
      bus.fwd_addr2 = '0;
      #12;
      chk("rst_reg_write", 64'(bus.reg_write), 0);
      chk("rst_write_addr", 64'(bus.write_addr), 0);
      chk("rst_write_data", 64'(bus.write_data), 0);
      chk("rst_in_ready", 64'(bus.in_ready), 1);
      chk("rst_empty", 64'(bus.empty), 1);
      chk("rst_full", 64'(bus.full), 0);
      chk("rst_fwd_hit1", 64'(bus.fwd_hit1), 0);
      chk("rst_fwd_hit2", 64'(bus.fwd_hit2), 0);
      #1 rst_n = 1'b1;

      // single entry latency
      cycle(1, 5, 32'hAAAA_0001, 0, 5, 0);
      idle(3, 0);

      // fill under stall, fifth offer refused, then drain with wrap
      for (int r = 1; r <= 4; r++)
         cycle(1, 5'(r), 32'h100 + r, 1, 5'(r), 3);
      cycle(1, 9, 32'h999, 1, 9, 4);
      cycle(1, 10, 32'hA0A, 1, 4, 10);
      idle(6, 0);

      // two writes to the same rd, youngest forwarded
      cycle(1, 7, 32'h11, 1, 7, 0);
      cycle(1, 7, 32'h22, 1, 7, 0);
      cycle(0, 0, 0, 1, 7, 0);
      cycle(0, 0, 0, 0, 7, 0);
      cycle(0, 0, 0, 0, 7, 0);
      cycle(0, 0, 0, 0, 7, 0);

      // x0 result
      cycle(1, 0, 32'hDEAD, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      idle(2, 0);

      // steady occupancy one with push and pop every cycle
      cycle(1, 5'($urandom_range(31, 1)), $urandom, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         cycle(1, 5'($urandom_range(31, 1)), $urandom, 0,
               5'($urandom_range(31, 0)), 0);
      idle(3, 0);

      // asynchronous reset with three entries queued
      cycle(1, 3, 32'h33, 1, 3, 6);
      cycle(1, 6, 32'h66, 1, 3, 6);
      cycle(1, 8, 32'h88, 1, 3, 6);
      cycle(0, 0, 0, 1, 3, 6);
      @(negedge clk);
      #2;
      rst_n  = 1'b0;
      pend_v = 1'b0;
      q.delete();
      #1;
      chk("midrst_reg_write", 64'(bus.reg_write), 0);
      chk("midrst_count", 64'(bus.count), 0);
      chk("midrst_fwd_hit1", 64'(bus.fwd_hit1), 0);
      chk("midrst_fwd_hit2", 64'(bus.fwd_hit2), 0);
      #1 rst_n = 1'b1;
      cycle(0, 0, 0, 0, 3, 6);
      idle(3, 0);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(99, 0) < 60,
               5'($urandom_range(7, 0)), $urandom,
               $urandom_range(99, 0) < 30,
               5'($urandom_range(7, 0)),
               5'($urandom_range(7, 0)));
      idle(8, 0);
      @(posedge clk);
      #1;
      chk("final_drained", 64'(bus.count), 64'(q.size()));
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
